// File: rtl/pc_seq.sv
// picoMIPS program counter with optional hardware return-address stack.
// Define PC_RETSTACK_EN to build the stack; without it call/ret degrade to jump/increment.
module pc_seq #(
    parameter int unsigned Psize = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             PCincr,
    input  logic             PCrelbranch,
    input  logic             PCabsbranch,
    input  logic             PCcall,
    input  logic             PCret,
    input  logic [Psize-1:0] Branchaddr,
    output logic [Psize-1:0] PCout,
    output logic             StackEmpty,
    output logic             StackFull,
    output logic             StackErr
);

    localparam int unsigned PW = Psize;

    if (Depth < 2 || Depth > 16) begin : g_depth_chk
        $error("pc_seq: Depth must be within 2..16");
    end

    logic [PW-1:0] pc_q;
    logic [PW-1:0] pc_d;
    logic [PW-1:0] pc_inc;
    logic [PW-1:0] pc_rel;

    assign pc_inc = pc_q + PW'(1);
    // Modulo-2^Psize add makes the offset behave as sign-extended two's complement.
    assign pc_rel = pc_q + Branchaddr;

`ifdef PC_RETSTACK_EN
    localparam int unsigned SPW = $clog2(Depth + 1);
    localparam int unsigned AW  = $clog2(Depth);

    logic [PW-1:0]  stack_q [Depth];
    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_d;
    logic           err_q;
    logic           err_d;
    logic           push;
    logic           empty;
    logic           full;
    logic [AW-1:0]  push_idx;
    logic [AW-1:0]  pop_idx;

    assign empty    = (sp_q == '0);
    assign full     = (sp_q == SPW'(Depth));
    assign push_idx = AW'(sp_q);
    assign pop_idx  = AW'(sp_q - SPW'(1));

    // Next PC / pointer / error, ret > call > abs > rel > incr.
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        if (PCret) begin
            if (empty) begin
                pc_d  = pc_inc;
                err_d = 1'b1;
            end else begin
                pc_d = stack_q[pop_idx];
                sp_d = sp_q - SPW'(1);
            end
        end else if (PCcall) begin
            pc_d = Branchaddr;
            if (full) begin
                err_d = 1'b1;
            end else begin
                push = 1'b1;
                sp_d = sp_q + SPW'(1);
            end
        end else if (PCabsbranch) begin
            pc_d = Branchaddr;
        end else if (PCrelbranch) begin
            pc_d = pc_rel;
        end else if (PCincr) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else if (!stall) begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Storage is not reset; entries above sp are unreachable.
    always_ff @(posedge clk) begin
        if (!stall && push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign StackEmpty = empty;
    assign StackFull  = full;
    assign StackErr   = err_q;
`else
    // Call acts as an absolute jump and ret as an increment, keeping their priority slots.
    always_comb begin
        pc_d = pc_q;
        if (PCret) begin
            pc_d = pc_inc;
        end else if (PCcall || PCabsbranch) begin
            pc_d = Branchaddr;
        end else if (PCrelbranch) begin
            pc_d = pc_rel;
        end else if (PCincr) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else if (!stall) begin
            pc_q <= pc_d;
        end
    end

    assign StackEmpty = 1'b1;
    assign StackFull  = 1'b0;
    assign StackErr   = 1'b0;
`endif

    assign PCout = pc_q;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed test-plan sequence plus random stimulus
// against a queue-based reference model (honours PC_RETSTACK_EN).
module tb_pc_seq;

    localparam int unsigned PSIZE = 8;
    localparam int unsigned DEPTH = 4;
    localparam int          MOD   = 1 << PSIZE;

    logic             clk;
    logic             reset;
    logic             stall;
    logic             PCincr;
    logic             PCrelbranch;
    logic             PCabsbranch;
    logic             PCcall;
    logic             PCret;
    logic [PSIZE-1:0] Branchaddr;
    logic [PSIZE-1:0] PCout;
    logic             StackEmpty;
    logic             StackFull;
    logic             StackErr;

    pc_seq #(.Psize(PSIZE), .Depth(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .PCincr     (PCincr),
        .PCrelbranch(PCrelbranch),
        .PCabsbranch(PCabsbranch),
        .PCcall     (PCcall),
        .PCret      (PCret),
        .Branchaddr (Branchaddr),
        .PCout      (PCout),
        .StackEmpty (StackEmpty),
        .StackFull  (StackFull),
        .StackErr   (StackErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PC_RETSTACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_pc;
    int m_stack[$];
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit c, input bit a, input bit b,
                              input bit i, input bit s, input int addr);
        int off;
        if (s) return;
        if (r) begin
            if (STACK_EN && m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin
                m_pc = (m_pc + 1) % MOD;
                if (STACK_EN) m_err = 1'b1;
            end
        end else if (c) begin
            if (STACK_EN) begin
                if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % MOD);
                else m_err = 1'b1;
            end
            m_pc = addr;
        end else if (a) begin
            m_pc = addr;
        end else if (b) begin
            off  = (addr >= MOD / 2) ? addr - MOD : addr;
            m_pc = ((m_pc + off) % MOD + MOD) % MOD;
        end else if (i) begin
            m_pc = (m_pc + 1) % MOD;
        end
    endtask

    task automatic check_all(input string tag);
        bit exp_empty;
        bit exp_full;
        exp_empty = STACK_EN ? (m_stack.size() == 0) : 1'b1;
        exp_full  = STACK_EN ? (m_stack.size() == DEPTH) : 1'b0;
        check({tag, ".pc"},    32'(PCout),      32'(m_pc));
        check({tag, ".empty"}, 32'(StackEmpty), 32'(exp_empty));
        check({tag, ".full"},  32'(StackFull),  32'(exp_full));
        check({tag, ".err"},   32'(StackErr),   32'(m_err));
    endtask

    task automatic step(input string tag, input bit r, input bit c, input bit a, input bit b,
                        input bit i, input bit s, input int addr);
        PCret       = r;
        PCcall      = c;
        PCabsbranch = a;
        PCrelbranch = b;
        PCincr      = i;
        stall       = s;
        Branchaddr  = PSIZE'(addr);
        @(posedge clk);
        #1;
        model_step(r, c, a, b, i, s, addr);
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        {stall, PCincr, PCrelbranch, PCabsbranch, PCcall, PCret} = '0;
        Branchaddr = '0;
        model_reset();
        #12;
        reset = 1'b0;
        check_all("reset");

        // Increment sequence then async reset mid-cycle
        for (int k = 0; k < 3; k++) step("incr", 0, 0, 0, 0, 1, 0, 0);
        check("incr3", 32'(PCout), 32'd3);
        #2 reset = 1'b1;
        #1 check("async_rst", 32'(PCout), 32'd0);
        #2 reset = 1'b0;
        model_reset();

        // Relative branch backwards and wrap-around
        step("abs10", 0, 0, 1, 0, 0, 0, 'h10);
        step("rel",   0, 0, 0, 1, 0, 0, 'hFC);
        check("rel_0c", 32'(PCout), 32'h0C);
        step("absff", 0, 0, 1, 0, 0, 0, 'hFF);
        step("wrap",  0, 0, 0, 0, 1, 0, 0);
        check("wrap_00", 32'(PCout), 32'h00);

        // Single call / return
        step("abs05", 0, 0, 1, 0, 0, 0, 'h05);
        step("call",  0, 1, 0, 0, 0, 0, 'h40);
        step("ret",   1, 0, 0, 0, 0, 0, 0);
`ifdef PC_RETSTACK_EN
        check("ret_06", 32'(PCout), 32'h06);
`endif

        // Nested calls past full, then unwind
        for (int k = 0; k < 5; k++) step("ncall", 0, 1, 0, 0, 0, 0, 'h10 * (k + 1));
        for (int k = 0; k < 4; k++) step("nret", 1, 0, 0, 0, 0, 0, 0);

        // Underflow at 0x20
        step("abs20", 0, 0, 1, 0, 0, 0, 'h20);
        step("uflow", 1, 0, 0, 0, 0, 0, 0);
        check("uflow_21", 32'(PCout), 32'h21);
        step("sticky", 0, 0, 0, 0, 1, 0, 0);

        // Stall overrides everything; ret beats incr
        step("stall",   0, 1, 0, 0, 1, 1, 'h77);
        step("call2",   0, 1, 0, 0, 0, 0, 'h60);
        step("ret_inc", 1, 0, 0, 0, 1, 0, 0);

        // Async reset while stalled with a call held
        PCcall = 1'b1; stall = 1'b1; Branchaddr = 8'h33;
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check("rst_stall.pc", 32'(PCout), 32'd0);
        check("rst_stall.empty", 32'(StackEmpty), 32'd1);
        check("rst_stall.err",   32'(StackErr),   32'd0);
        #1 reset = 1'b0;
        model_reset();
        {stall, PCcall} = '0;

        // Random stimulus against the model
        for (int k = 0; k < 400; k++) begin
            step("rand",
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, MOD - 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised picoMIPS program counter with a hardware return-address stack. It sits between the decoder and program memory, drives the instruction address, and supports increment, signed relative branch, absolute jump, subroutine call and return. A stall input freezes the block, and sticky error flags report stack overflow and underflow.

## Interface
- `Psize`, default 8: PC width; address space 2^Psize instructions.
- `Depth`, default 4: return-stack entries; legal range 2..16.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: freeze all state this cycle.
- `PCincr` in 1: PC <= PC + 1.
- `PCrelbranch` in 1: PC <= PC + sign-extended `Branchaddr`.
- `PCabsbranch` in 1: PC <= `Branchaddr`.
- `PCcall` in 1: push PC + 1, then PC <= `Branchaddr`.
- `PCret` in 1: PC <= popped top of stack.
- `Branchaddr` in Psize: two's-complement offset for relative branches; absolute target for jumps and calls.
- `PCout` out Psize: current instruction address, registered.
- `StackEmpty` out 1: stack holds 0 entries.
- `StackFull` out 1: stack holds `Depth` entries.
- `StackErr` out 1: sticky; set on overflow or underflow.

## Operation
- Exactly one action is applied per un-stalled cycle. Priority, highest first:
  1. `PCret`
  2. `PCcall`
  3. `PCabsbranch`
  4. `PCrelbranch`
  5. `PCincr`
- With no control input asserted, PC holds.
- `stall`=1 overrides every control input: PC, stack, pointer and `StackErr` all hold.
- All PC arithmetic is modulo 2^Psize:
  - 0xFF + 1 -> 0x00 (Psize=8).
  - Relative offset 0xFE means -2.
- Stack is a LIFO register array with occupancy pointer `sp` of width $clog2(Depth+1).
  - Call pushes to entry `sp`, then `sp`++.
  - Return reads entry `sp`-1, then `sp`--.
- Call when full:
  - No push; `sp` unchanged.
  - PC still jumps to `Branchaddr`.
  - `StackErr` <= 1.
- Return when empty:
  - No pop; PC <= PC + 1.
  - `StackErr` <= 1.
- `StackErr` clears only on reset.
- `StackEmpty` = (`sp`==0) and `StackFull` = (`sp`==Depth). Both are decoded combinationally from the registered `sp`.
- Stack contents are not cleared by reset. Only `sp` resets, so stale entries are unreachable.

## Timing
- Reset values: `PCout`=0, `sp`=0, `StackEmpty`=1, `StackFull`=0, `StackErr`=0.
- Assertion of `reset` takes effect immediately, independent of `clk`. This includes mid-call and mid-stall.
- All state updates on the rising edge of `clk`. Controls sampled at edge N are visible on `PCout` after edge N, i.e. one-cycle latency. There is no combinational path from inputs to `PCout`.
- Push and pop complete in one cycle.
- Back-to-back call then ret returns the pushed address in the cycle after the ret edge.
- `StackErr` sets at the same edge as the faulting call or return.

## Configuration
- `PC_RETSTACK_EN` defined: full behaviour as above.
- `PC_RETSTACK_EN` undefined:
  - No stack storage or pointer is generated.
  - `PCcall` behaves as `PCabsbranch` and keeps its priority slot.
  - `PCret` behaves as `PCincr` and keeps its priority slot.
  - `StackEmpty`=1, `StackFull`=0, `StackErr`=0, all constant.
  - `Depth` is ignored.

## Test plan
- Reset, then 3 cycles of `PCincr` -> `PCout` 0,1,2,3. Assert `reset` asynchronously mid-cycle -> `PCout`=0 immediately.
- `PCout`=0x10 with `PCrelbranch` and `Branchaddr`=0xFC -> 0x0C. At 0xFF with `PCincr` -> 0x00.
- At 0x05, `PCcall` to 0x40 -> `PCout`=0x40, `StackEmpty`=0. Then `PCret` -> `PCout`=0x06, `StackEmpty`=1.
- Depth=4: five nested calls -> `StackFull`=1 after the 4th. The 5th jumps but sets `StackErr`=1. Four returns then pop the original four return addresses in reverse order.
- With `sp`=0, `PCret` at 0x20 -> `PCout`=0x21 and `StackErr`=1. `StackErr` stays 1 until reset.
- `stall`=1 with `PCcall` and `PCincr` asserted -> `PCout`, `sp` and flags unchanged. `PCret` and `PCincr` together -> the ret wins.
